// File: rtl/chip8_bus_loader.sv
// chip8_bus_loader: bus initiator that pauses the Chip8 core, optionally
// writes the hex font, streams a ROM image into memory, sets SP/PC,
// releases the core and reads the state register back.
module chip8_bus_loader #(
  parameter logic [11:0] PROG_BASE = 12'h200,
  parameter int unsigned MAX_PROG  = 3584,
  parameter bit          LOAD_FONT = 1'b1,
  parameter logic [11:0] FONT_BASE = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rom_data,
  input  logic        rom_valid,
  input  logic        rom_last,
  output logic        rom_ready,
  output logic        chipselect,
  output logic        write,
  output logic [17:0] address,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] bytes_loaded
);

  localparam logic [17:0] REG_SP    = 18'h00013;
  localparam logic [17:0] REG_PC    = 18'h00014;
  localparam logic [17:0] REG_STATE = 18'h00016;
  localparam logic [11:0] MAX_CNT   = 12'(MAX_PROG);
  localparam logic [6:0]  FONT_LAST = 7'd79;

  typedef enum logic [3:0] {
    S_IDLE, S_LOADING, S_FONT_HDR, S_FONT, S_PROG, S_SET_SP,
    S_SET_PC, S_SET_RUN, S_RD_REQ, S_RD_WAIT, S_FAIL, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [6:0]  font_idx, font_idx_nxt;
  logic [11:0] count_nxt;
  logic        error_nxt;

  // Standard Chip8 glyph rows: glyph k/5, row k%5, packed MSB-first.
  function automatic logic [7:0] font_byte(input logic [6:0] k);
    logic [39:0] g;
    logic [3:0]  digit;
    logic [2:0]  row;
    digit = 4'(k / 7'd5);
    row   = 3'(k % 7'd5);
    case (digit)
      4'h0: g = 40'hF0909090F0;
      4'h1: g = 40'h2060202070;
      4'h2: g = 40'hF010F080F0;
      4'h3: g = 40'hF010F010F0;
      4'h4: g = 40'h9090F01010;
      4'h5: g = 40'hF080F010F0;
      4'h6: g = 40'hF080F090F0;
      4'h7: g = 40'hF010204040;
      4'h8: g = 40'hF090F090F0;
      4'h9: g = 40'hF090F010F0;
      4'hA: g = 40'hF090F09090;
      4'hB: g = 40'hE090E090E0;
      4'hC: g = 40'hF0808080F0;
      4'hD: g = 40'hE0909090E0;
      4'hE: g = 40'hF080F080F0;
      4'hF: g = 40'hF080F08080;
      default: g = 40'h0;
    endcase
    g = g << {row, 3'b000};
    return g[39:32];
  endfunction

  // State, font counter, program byte count and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      font_idx     <= 7'd0;
      bytes_loaded <= 12'd0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      font_idx     <= font_idx_nxt;
      bytes_loaded <= count_nxt;
      error        <= error_nxt;
    end
  end

  // Next-state logic and the single bus transaction issued this cycle.
  always_comb begin
    state_nxt    = state;
    font_idx_nxt = font_idx;
    count_nxt    = bytes_loaded;
    error_nxt    = error;
    rom_ready    = 1'b0;
    chipselect   = 1'b0;
    write        = 1'b0;
    address      = 18'h00000;
    writedata    = 32'h00000000;
    busy         = (state != S_IDLE) && (state != S_DONE);
    done         = (state == S_DONE);
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_nxt = 12'd0;
          error_nxt = 1'b0;
          state_nxt = S_LOADING;
        end else begin
          state_nxt = state;
        end
      end
      S_LOADING: begin
        chipselect   = 1'b1;
        write        = 1'b1;
        address      = REG_STATE;
        writedata    = 32'd2;
        font_idx_nxt = 7'd0;
        state_nxt    = LOAD_FONT ? S_FONT_HDR : S_PROG;
      end
      S_FONT_HDR: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_STATE;
        writedata  = 32'd3;
        state_nxt  = S_FONT;
      end
      S_FONT: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = {2'b01, 4'b0000, FONT_BASE + {5'b00000, font_idx}};
        writedata  = {24'h000000, font_byte(font_idx)};
        if (font_idx == FONT_LAST) begin
          state_nxt = S_PROG;
        end else begin
          font_idx_nxt = font_idx + 7'd1;
        end
      end
      S_PROG: begin
        // A byte offered once the program area is full is refused.
        rom_ready = (bytes_loaded != MAX_CNT);
        if (rom_valid && rom_ready) begin
          chipselect = 1'b1;
          write      = 1'b1;
          address    = {2'b01, 4'b0000, PROG_BASE + bytes_loaded};
          writedata  = {24'h000000, rom_data};
          count_nxt  = bytes_loaded + 12'd1;
          state_nxt  = rom_last ? S_SET_SP : S_PROG;
        end else if (rom_valid) begin
          state_nxt = S_FAIL;
        end else begin
          state_nxt = S_PROG;
        end
      end
      S_SET_SP: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_SP;
        writedata  = 32'd0;
        state_nxt  = S_SET_PC;
      end
      S_SET_PC: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_PC;
        writedata  = {20'h00000, PROG_BASE};
        state_nxt  = S_SET_RUN;
      end
      S_SET_RUN: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_STATE;
        writedata  = 32'd0;
        state_nxt  = S_RD_REQ;
      end
      S_RD_REQ: begin
        chipselect = 1'b1;
        address    = REG_STATE;
        state_nxt  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Core must report RUNNING after the release write.
        error_nxt = (readdata[1:0] != 2'b00);
        state_nxt = S_DONE;
      end
      S_FAIL: begin
        // Leave the core paused on an oversized image.
        chipselect = 1'b1;
        write      = 1'b1;
        address    = REG_STATE;
        writedata  = 32'd1;
        error_nxt  = 1'b1;
        state_nxt  = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_chip8_bus_loader.sv
// Self-checking bench: two loaders (no font / font with 4-byte limit) against
// a slave model and a transaction-list reference built from the load rules.
module tb_chip8_bus_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        start [2];
  logic        rvalid [2];
  logic        rlast [2];
  logic [7:0]  rbyte [2];
  logic        rready [2];
  logic        cs [2];
  logic        wr [2];
  logic [17:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdback [2];
  logic        busy [2];
  logic        done [2];
  logic        err [2];
  logic [11:0] nload [2];
  logic [31:0] slv_state [2];
  logic        ovr_en [2];
  logic [31:0] ovr_val [2];

  logic [50:0] log0 [$];
  logic [50:0] log1 [$];
  logic [7:0]  font_tab [80];
  int tests = 0;
  int fails = 0;

  chip8_bus_loader #(.LOAD_FONT(1'b0)) dut_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .rom_data(rbyte[0]),
    .rom_valid(rvalid[0]), .rom_last(rlast[0]), .rom_ready(rready[0]),
    .chipselect(cs[0]), .write(wr[0]), .address(addr[0]), .writedata(wdata[0]),
    .readdata(rdback[0]), .busy(busy[0]), .done(done[0]), .error(err[0]),
    .bytes_loaded(nload[0]));

  chip8_bus_loader #(.LOAD_FONT(1'b1), .MAX_PROG(4)) dut_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .rom_data(rbyte[1]),
    .rom_valid(rvalid[1]), .rom_last(rlast[1]), .rom_ready(rready[1]),
    .chipselect(cs[1]), .write(wr[1]), .address(addr[1]), .writedata(wdata[1]),
    .readdata(rdback[1]), .busy(busy[1]), .done(done[1]), .error(err[1]),
    .bytes_loaded(nload[1]));

  // Slave model: state register 0x16, read data returned the cycle after a read strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        slv_state[d] <= 32'd0;
        rdback[d]    <= 32'd0;
      end else if (cs[d] && wr[d] && addr[d] == 18'h00016) begin
        slv_state[d] <= wdata[d];
      end else if (cs[d] && !wr[d]) begin
        rdback[d] <= ovr_en[d] ? ovr_val[d] : slv_state[d];
      end
    end
  end

  // Bus monitor: log every transaction as {write, address, data}.
  always @(negedge clk) begin
    if (cs[0] === 1'b1) log0.push_back({wr[0], addr[0], wr[0] ? wdata[0] : 32'd0});
    if (cs[1] === 1'b1) log1.push_back({wr[1], addr[1], wr[1] ? wdata[1] : 32'd0});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [50:0] reg_wr(input logic [17:0] a, input logic [31:0] v);
    return {1'b1, a, v};
  endfunction

  function automatic logic [50:0] mem_wr(input logic [11:0] a, input logic [7:0] b);
    return {1'b1, 2'b01, 4'b0000, a, 24'd0, b};
  endfunction

  // Offer one byte; returns once it has been transferred or the wait expires.
  task automatic push_byte(input int d, input logic [7:0] b, input bit last, output bit ok);
    ok = 1'b0;
    rvalid[d] = 1'b1;
    rbyte[d]  = b;
    rlast[d]  = last;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (rready[d] === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    rvalid[d] = 1'b0;
    rlast[d]  = 1'b0;
  endtask

  // One full load: gap < 0 means random 0..3 idle cycles between bytes.
  task automatic run_seq(input int d, input logic [7:0] data[$], input int last_idx,
                         input int gap, input bit rd_err, input string tag);
    logic [50:0] exp_q [$];
    logic [50:0] got_q [$];
    int  max_n;
    int  n_acc;
    int  accepted;
    int  n;
    bit  ovf;
    bit  ok;
    max_n = (d == 0) ? 3584 : 4;
    ovf   = !(last_idx >= 0 && last_idx < max_n);
    n_acc = ovf ? max_n : last_idx + 1;

    exp_q.push_back(reg_wr(18'h16, 32'd2));
    if (d == 1) begin
      exp_q.push_back(reg_wr(18'h16, 32'd3));
      for (int k = 0; k < 80; k++) exp_q.push_back(mem_wr(12'(k), font_tab[k]));
    end
    for (int i = 0; i < n_acc; i++) exp_q.push_back(mem_wr(12'(12'h200 + i), data[i]));
    if (ovf) begin
      exp_q.push_back(reg_wr(18'h16, 32'd1));
    end else begin
      exp_q.push_back(reg_wr(18'h13, 32'd0));
      exp_q.push_back(reg_wr(18'h14, 32'h200));
      exp_q.push_back(reg_wr(18'h16, 32'd0));
      exp_q.push_back({1'b0, 18'h16, 32'd0});
    end

    if (d == 0) log0.delete(); else log1.delete();
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    accepted = 0;
    for (int i = 0; i < data.size(); i++) begin
      if (i > 0) repeat ((gap < 0) ? $urandom_range(0, 3) : gap) @(negedge clk);
      push_byte(d, data[i], (i == last_idx), ok);
      if (!ok) break;
      accepted++;
      if (i == last_idx) break;
      if (i == 0) begin
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
      end
    end
    for (int c = 0; c < 500 && done[d] !== 1'b1; c++) @(negedge clk);

    check({tag, "_done"}, 64'(done[d]), 64'd1);
    check({tag, "_busy"}, 64'(busy[d]), 64'd0);
    check({tag, "_error"}, 64'(err[d]), 64'(ovf || rd_err));
    check({tag, "_bytes_loaded"}, 64'(nload[d]), 64'(n_acc));
    check({tag, "_accepted"}, 64'(accepted), 64'(n_acc));
    if (d == 0) got_q = log0; else got_q = log1;
    check({tag, "_txn_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_txn%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    logic [639:0] fb;
    logic [7:0]   data [$];
    bit           ok;
    int           len;

    fb = {40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
          40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
          40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
          40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080};
    for (int k = 0; k < 80; k++) font_tab[k] = fb[639 - 8*k -: 8];

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; rvalid[d] = 1'b0; rlast[d] = 1'b0;
      rbyte[d] = 8'd0; ovr_en[d] = 1'b0; ovr_val[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("reset_outs%0d", d),
            64'({rready[d], cs[d], busy[d], done[d], err[d], nload[d]}), 64'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Fixed three-byte image, no font.
    data = '{8'h12, 8'h34, 8'h56};
    run_seq(0, data, 2, 0, 1'b0, "t1");

    // Random images with random gaps, no font.
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 24);
      data.delete();
      for (int i = 0; i < len; i++) data.push_back(8'($urandom));
      run_seq(0, data, len - 1, -1, 1'b0, $sformatf("rnd%0d", r));
    end

    // Font then a short program.
    data = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run_seq(1, data, 2, -1, 1'b0, "t2");

    // valid 1,0,0,1(last): two writes, contiguous addresses, idle gap.
    data = '{8'hAB, 8'hCD};
    run_seq(0, data, 1, 2, 1'b0, "t3");

    // Five bytes with no last against a 4-byte limit.
    data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_seq(1, data, -1, -1, 1'b0, "t4");

    // Readback reports PAUSED-ish value 2.
    ovr_en[0]  = 1'b1;
    ovr_val[0] = 32'd2;
    data = '{8'h11, 8'h22};
    run_seq(0, data, 1, 0, 1'b1, "t5rd");
    ovr_en[0] = 1'b0;

    // Reset during the second program byte.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    push_byte(0, 8'hA5, 1'b0, ok);
    check("t5_byte1_ok", 64'(ok), 64'd1);
    rvalid[0] = 1'b1;
    rbyte[0]  = 8'h5A;
    rst[0]    = 1'b1;
    @(negedge clk);
    rvalid[0] = 1'b0;
    check("t5_reset_outs",
          64'({rready[0], cs[0], busy[0], done[0], err[0], nload[0]}), 64'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    data = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_seq(0, data, 3, -1, 1'b0, "t5clean");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
